hazard_stall_controller: RTL
============================

// Module: hazard_stall_controller
// PURPOSE
//  Central hazard sequencer for the 5-stage pipeline. Generates the stall for the
//  fetch stage / IF-ID register, the ID-EX bubble, the IF-ID flush and the gated
//  jump enable to the PC. Tracks multi-cycle MULT/DIV occupancy of HI/LO with a
//  down-counter FSM. Keeps a stall-cycle performance counter.
//  Sits beside the ID stage, between decode and the fetch/PC logic.
// PARAMETERS
//  MUL_LATENCY  5   cycles HI/LO busy after a MULT/MULTU issues from EX (>=1)
//  DIV_LATENCY  32  cycles HI/LO busy after a DIV/DIVU issues from EX (>=1)
//  CNT_W        6   width of busy down-counter; must hold max(MUL,DIV)_LATENCY
// PORTS
//  clock          in   1   system clock, all state on posedge
//  reset          in   1   synchronous, active-high
//  id_rs          in   5   rs field of instruction in ID
//  id_rt          in   5   rt field of instruction in ID
//  id_uses_rt     in   1   ID instruction reads rt as a source
//  id_uses_hilo   in   1   ID instr is MFHI/MFLO/MTHI/MTLO/MULT*/DIV*
//  ex_mem_read    in   1   EX instruction is a load
//  ex_rt          in   5   destination register of the EX load
//  md_start       in   1   1-cycle pulse: MULT/DIV op is in EX this cycle
//  md_is_div      in   1   qualifies md_start: 1=divide, 0=multiply
//  jump_req       in   1   branch/jump resolved taken in ID
//  stall_fetch    out  1   hold PC and IF-ID register (drives stallFromDecode)
//  bubble_ex      out  1   load bubble (NOP) into ID-EX register
//  flush_if_id    out  1   replace IF-ID contents with bubble instruction
//  jump_accept    out  1   gated jump enable to the PC
//  md_busy        out  1   HI/LO unit occupied (FSM in MD_BUSY)
//  stall_cycles   out  32  count of cycles with stall_fetch=1
// BEHAVIOUR
//  FSM states: RUN, MD_BUSY. Reset -> RUN, busy counter 0, stall_cycles 0.
//  - RUN:     md_start=1 -> MD_BUSY, counter <= md_is_div ? DIV_LATENCY-1 : MUL_LATENCY-1.
//  - MD_BUSY: counter decrements each cycle; at counter==0 -> RUN next cycle.
//    md_start in MD_BUSY is a protocol violation (prevented by stall); ignored.
//  - md_busy = (state==MD_BUSY): 1 for exactly LATENCY cycles after md_start.
//  Hazard terms, combinational, same cycle as inputs:
//  - load_use = ex_mem_read & ex_rt!=0 & (ex_rt==id_rs | (id_uses_rt & ex_rt==id_rt)).
//  - hilo_haz = md_busy & id_uses_hilo.
//  - stall_fetch = bubble_ex = load_use | hilo_haz.
//  - jump_accept = jump_req & ~stall_fetch. A jump waiting on an operand retries
//    after the stall clears.
//  - flush_if_id = jump_accept. The wrong-path fetch is squashed; it is
//    never asserted together with stall_fetch.
//  - All four hazard outputs are 0 while reset=1.
//  stall_cycles increments on every clock edge with stall_fetch=1 (not during reset).
//  It wraps at 2^32-1 -> 0.
//  Reset mid-MD_BUSY: returns to RUN next edge, counter cleared, md_busy=0.
//  Registers ex_rt==0 never cause load-use stall.
// TESTING
//  1. Load-use: ex_mem_read=1, ex_rt=8, id_rs=8 -> stall_fetch=1, bubble_ex=1 that cycle.
//     Next cycle (ex_mem_read=0): both 0. stall_cycles=1.
//  2. rt unused: ex_rt=9, id_rt=9, id_uses_rt=0, id_rs=3 -> no stall.
//     Repeat with ex_rt=0, id_rs=0 -> no stall.
//  3. DIV: md_start=1, md_is_div=1 -> md_busy=1 for 32 cycles. With id_uses_hilo=1
//     throughout, stall_fetch=1 for those 32 cycles, then 0. stall_cycles=32.
//  4. Jump vs stall: jump_req=1 with load_use true -> jump_accept=0, flush_if_id=0.
//     Next cycle, no hazard -> jump_accept=1, flush_if_id=1.
//  5. Reset mid-operation: MULT issued, reset at busy cycle 2 -> next cycle md_busy=0,
//     state RUN, stall_cycles=0, all outputs 0.
//  6. MULT then unrelated instrs (id_uses_hilo=0) -> md_busy high 5 cycles,
//     stall_fetch stays 0.

Source files
------------

// File: rtl/hazard_stall_controller_if.sv
// ============================================================================
// Module : hazard_stall_controller_if
// Brief  : Decode-side hazard bus between ID/EX/PC logic and the hazard
//          stall controller.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface hazard_stall_controller_if;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rt;
    logic        id_uses_hilo;
    logic        ex_mem_read;
    logic [4:0]  ex_rt;
    logic        md_start;
    logic        md_is_div;
    logic        jump_req;
    logic        stall_fetch;
    logic        bubble_ex;
    logic        flush_if_id;
    logic        jump_accept;
    logic        md_busy;
    logic [31:0] stall_cycles;

    // Pipeline side: drives decode/EX status, consumes stall controls
    modport master (
        output id_rs, id_rt, id_uses_rt, id_uses_hilo,
        output ex_mem_read, ex_rt, md_start, md_is_div, jump_req,
        input  stall_fetch, bubble_ex, flush_if_id, jump_accept,
        input  md_busy, stall_cycles
    );

    // Controller side
    modport slave (
        input  id_rs, id_rt, id_uses_rt, id_uses_hilo,
        input  ex_mem_read, ex_rt, md_start, md_is_div, jump_req,
        output stall_fetch, bubble_ex, flush_if_id, jump_accept,
        output md_busy, stall_cycles
    );
endinterface

`default_nettype wire

// File: rtl/hazard_stall_controller.sv
// ============================================================================
// Module : hazard_stall_controller
// Brief  : Load-use / HI-LO hazard stall, bubble, flush and jump gating for
//          the 5-stage pipeline, with MULT/DIV occupancy FSM and stall counter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module hazard_stall_controller #(
    parameter int MUL_LATENCY = 5,
    parameter int DIV_LATENCY = 32,
    parameter int CNT_W       = 6
) (
    input  wire logic                 clock,
    input  wire logic                 reset,
    hazard_stall_controller_if.slave  hz
);

    localparam logic [CNT_W-1:0] c_MUL_LOAD = CNT_W'(MUL_LATENCY - 1);
    localparam logic [CNT_W-1:0] c_DIV_LOAD = CNT_W'(DIV_LATENCY - 1);

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_next;
    logic [31:0]        r_stall_cycles;

    logic w_md_busy;
    logic w_load_use;
    logic w_hilo_haz;
    logic w_stall;
    logic w_jump_accept;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // md_start while busy cannot happen (decode is stalled on HI/LO), so it is ignored
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            RUN: begin
                if (hz.md_start) begin
                    w_state_next = MD_BUSY;
                    w_cnt_next   = hz.md_is_div ? c_DIV_LOAD : c_MUL_LOAD;
                end
            end
            MD_BUSY: begin
                if (r_cnt == '0) begin
                    w_state_next = RUN;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_next = RUN;
                w_cnt_next   = '0;
            end
        endcase
    end

    assign w_md_busy  = (r_state == MD_BUSY);

    // r0 is hard-wired zero, so a load targeting it never creates a dependency
    assign w_load_use = hz.ex_mem_read && (hz.ex_rt != 5'd0) &&
                        ((hz.ex_rt == hz.id_rs) ||
                         (hz.id_uses_rt && (hz.ex_rt == hz.id_rt)));
    assign w_hilo_haz = w_md_busy && hz.id_uses_hilo;

    assign w_stall       = !reset && (w_load_use || w_hilo_haz);
    assign w_jump_accept = !reset && hz.jump_req && !w_stall;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_stall_cycles <= '0;
        end else if (w_stall) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign hz.stall_fetch  = w_stall;
    assign hz.bubble_ex    = w_stall;
    assign hz.jump_accept  = w_jump_accept;
    assign hz.flush_if_id  = w_jump_accept;
    assign hz.md_busy      = w_md_busy;
    assign hz.stall_cycles = r_stall_cycles;

endmodule

`default_nettype wire
